// File: rtl/mtimer_multi.sv
// Multi-channel machine timer: shared prescaled mtime, NUM_CH compare/soft-irq channels, req/ack register bus.
// Bus access completes with bus_ack one cycle after acceptance; at most one access every two cycles, no stalls.
module mtimer_multi #(
  parameter int NUM_CH         = 2,
  parameter int TIME_WIDTH     = 64,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic              clk_timer,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [15:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ack,
  output logic [31:0]       bus_rdata,
  output logic [NUM_CH-1:0] timer_irq,
  output logic [NUM_CH-1:0] soft_irq,
  output logic              tick
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                    state_q, state_d;
  logic [TIME_WIDTH-1:0]     mtime_q, mtime_d;
  logic [TIME_WIDTH-1:0]     cmp_q [NUM_CH];
  logic [TIME_WIDTH-1:0]     cmp_d [NUM_CH];
  logic [NUM_CH-1:0]         msip_q, msip_d;
  logic [NUM_CH-1:0]         tirq_q, tirq_d;
  logic [NUM_CH-1:0]         sirq_q;
  logic                      en_q, en_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]               shadow_q, shadow_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      tick_q, fire, accept;
  logic                      is_msip, is_cmp, is_ctrl, is_presc, is_mlo, is_mhi;
  logic                      unused_addr;

  function automatic logic [TIME_WIDTH-1:0] put_word(input logic [TIME_WIDTH-1:0] cur,
                                                     input logic [31:0] w, input logic hi);
    logic [63:0] t;
    t = 64'(cur);
    if (hi) t[63:32] = w;
    else    t[31:0]  = w;
    return t[TIME_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] get_word(input logic [TIME_WIDTH-1:0] cur, input logic hi);
    logic [63:0] t;
    t = 64'(cur);
    return hi ? t[63:32] : t[31:0];
  endfunction

  assign unused_addr = ^bus_addr[1:0];

  assign is_msip  = (bus_addr[15:14] == 2'b00);
  assign is_cmp   = (bus_addr[15:14] == 2'b01);
  assign is_ctrl  = (bus_addr[15:2] == 14'h2FFC);
  assign is_presc = (bus_addr[15:2] == 14'h2FFD);
  assign is_mlo   = (bus_addr[15:2] == 14'h2FFE);
  assign is_mhi   = (bus_addr[15:2] == 14'h2FFF);

  assign accept = (state_q == S_IDLE) && bus_req;
  assign fire   = en_q && (pc_q == presc_q);

  always_comb begin
    state_d  = S_IDLE;
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    msip_d   = msip_q;
    en_d     = en_q;
    presc_d  = presc_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    rdata_d  = '0;
    tirq_d   = '0;

    if (en_q) begin
      if (fire) begin
        pc_d    = '0;
        mtime_d = mtime_q + TIME_WIDTH'(1);
      end else begin
        pc_d = pc_q + PRESCALE_WIDTH'(1);
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      tirq_d[i] = (mtime_q >= cmp_q[i]);
    end

    // Bus writes are applied after the counter update so a colliding mtime write wins.
    if (accept) begin
      state_d = S_ACK;
      for (int i = 0; i < NUM_CH; i++) begin
        if (is_msip && bus_addr[13:2] == 12'(i)) begin
          rdata_d = {31'd0, msip_q[i]};
          if (bus_we) msip_d[i] = bus_wdata[0];
        end
        if (is_cmp && bus_addr[13:3] == 11'(i)) begin
          rdata_d = get_word(cmp_q[i], bus_addr[2]);
          if (bus_we) cmp_d[i] = put_word(cmp_q[i], bus_wdata, bus_addr[2]);
        end
      end
      if (is_ctrl) begin
        rdata_d = {31'd0, en_q};
        if (bus_we) en_d = bus_wdata[0];
      end
      if (is_presc) begin
        rdata_d = 32'(presc_q);
        if (bus_we) begin
          presc_d = bus_wdata[PRESCALE_WIDTH-1:0];
          pc_d    = '0;
        end
      end
      // Low read latches the high half so a following high read is coherent.
      if (is_mlo) begin
        rdata_d = get_word(mtime_q, 1'b0);
        if (bus_we) mtime_d = put_word(mtime_q, bus_wdata, 1'b0);
        else        shadow_d = get_word(mtime_q, 1'b1);
      end
      if (is_mhi) begin
        rdata_d = shadow_q;
        if (bus_we) mtime_d = put_word(mtime_q, bus_wdata, 1'b1);
      end
    end
  end

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mtime_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) cmp_q[i] <= '1;
      msip_q   <= '0;
      tirq_q   <= '0;
      sirq_q   <= '0;
      en_q     <= 1'b1;
      presc_q  <= '0;
      pc_q     <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      tirq_q   <= tirq_d;
      sirq_q   <= msip_q;
      en_q     <= en_d;
      presc_q  <= presc_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      tick_q   <= fire;
    end
  end

  assign bus_ack   = (state_q == S_ACK);
  assign bus_rdata = rdata_q;
  assign timer_irq = tirq_q;
  assign soft_irq  = sirq_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_mtimer_multi.sv
// Directed self-checking bench for mtimer_multi (NUM_CH=2, 64-bit time, 16-bit prescaler).
module tb_mtimer_multi;

  logic        clk_timer = 1'b0;
  logic        rst;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  timer_irq, soft_irq;
  logic        tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  mtimer_multi #(.NUM_CH(2), .TIME_WIDTH(64), .PRESCALE_WIDTH(16)) dut (
    .clk_timer(clk_timer), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .timer_irq(timer_irq), .soft_irq(soft_irq), .tick(tick)
  );

  always #5 clk_timer = ~clk_timer;

  always @(negedge clk_timer) if (tick === 1'b1) tick_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Bus access: raise req, wait (bounded) for ack, return the read data.
  task automatic bus_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
    int n;
    n = 0;
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    do begin
      @(posedge clk_timer); #1;
      n++;
    end while (bus_ack !== 1'b1 && n < 8);
    checks++;
    if (bus_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout addr=%h got ack=%b want 1", addr, bus_ack);
    end
    rd = bus_rdata;
    bus_req = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_access(1'b1, addr, wd, dummy);
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] d);
    bus_access(1'b0, addr, 32'd0, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (2) @(posedge clk_timer); #1;
    checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", bus_ack); end
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus_rdata); end
    checks++; if (timer_irq !== 2'b00) begin errors++; $display("FAIL rst_timer_irq got %b want 00", timer_irq); end
    checks++; if (soft_irq !== 2'b00) begin errors++; $display("FAIL rst_soft_irq got %b want 00", soft_irq); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", tick); end
    // Accept an access, then reset during its ack cycle.
    @(negedge clk_timer); rst = 1'b1;
    bus_req = 1'b1; bus_addr = 16'hBFF0;
    @(posedge clk_timer); #1;
    checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL abort_pre_ack got %b want 1", bus_ack); end
    rst = 1'b0; #1;
    checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got %b want 0", bus_ack); end
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL abort_rdata got %h want 0", bus_rdata); end
    // Request already pending at release: accepted on the first edge, sees mtime=0.
    bus_addr = 16'hBFF8;
    @(negedge clk_timer); rst = 1'b1;
    @(posedge clk_timer); #1;
    checks++; if (bus_ack !== 1'b1) begin errors++; $display("FAIL first_ack got %b want 1", bus_ack); end
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL mtime_lo_rst got %h want 0", bus_rdata); end
    bus_req = 1'b0;
    rd(16'h4004, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp0_hi_rst got %h want ffffffff", d); end
    rd(16'hBFF0, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL ctrl_rst got %h want 1", d); end
    rd(16'hBFF4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL presc_rst got %h want 0", d); end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    wr(16'hBFF0, 32'd0);
    wr(16'hBFF4, 32'd3);
    wr(16'hBFF8, 32'd0);
    wr(16'hBFFC, 32'd0);
    tick_cnt = 0;
    wr(16'hBFF0, 32'd1);
    repeat (20) @(posedge clk_timer); #1;
    rd(16'hBFF8, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL presc_mtime got %0d want 5", d); end
    checks++; if (tick_cnt !== 5) begin errors++; $display("FAIL presc_ticks got %0d want 5", tick_cnt); end
    rd(16'hBFF4, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL presc_readback got %0d want 3", d); end
  endtask

  task automatic test_compare();
    wr(16'hBFF0, 32'd0);
    wr(16'hBFF4, 32'd0);
    wr(16'hBFF8, 32'd0);
    wr(16'hBFFC, 32'd0);
    wr(16'h4008, 32'd10);
    wr(16'h400C, 32'd0);
    wr(16'hBFF0, 32'd1);
    repeat (10) @(posedge clk_timer); #1;
    checks++; if (timer_irq !== 2'b00) begin errors++; $display("FAIL cmp_before got %b want 00", timer_irq); end
    @(posedge clk_timer); #1;
    checks++; if (timer_irq !== 2'b10) begin errors++; $display("FAIL cmp_rise got %b want 10", timer_irq); end
    wr(16'h400C, 32'd1);
    checks++; if (timer_irq[1] !== 1'b1) begin errors++; $display("FAIL cmp_hold got %b want 1", timer_irq[1]); end
    @(posedge clk_timer); #1;
    checks++; if (timer_irq[1] !== 1'b0) begin errors++; $display("FAIL cmp_clear got %b want 0", timer_irq[1]); end
  endtask

  task automatic test_coherent();
    logic [31:0] d;
    wr(16'hBFF0, 32'd0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'd0);
    rd(16'hBFF8, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL coh_lo got %h want ffffffff", d); end
    wr(16'hBFF0, 32'd1);
    repeat (5) @(posedge clk_timer); #1;
    rd(16'hBFFC, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL coh_shadow got %h want 0", d); end
    rd(16'hBFF8, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL coh_lo2 got %h want 6", d); end
    rd(16'hBFFC, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL coh_hi2 got %h want 1", d); end
  endtask

  task automatic test_wrap();
    wr(16'hBFF0, 32'd0);
    wr(16'h4000, 32'd5);
    wr(16'h4004, 32'd0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    checks++; if (timer_irq[0] !== 1'b1) begin errors++; $display("FAIL wrap_pre got %b want 1", timer_irq[0]); end
    wr(16'hBFF0, 32'd1);
    @(posedge clk_timer); #1;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL wrap_tick got %b want 1", tick); end
    checks++; if (timer_irq[0] !== 1'b1) begin errors++; $display("FAIL wrap_hold got %b want 1", timer_irq[0]); end
    @(posedge clk_timer); #1;
    checks++; if (timer_irq[0] !== 1'b0) begin errors++; $display("FAIL wrap_fall got %b want 0", timer_irq[0]); end
  endtask

  task automatic test_soft();
    logic [31:0] d;
    wr(16'h0004, 32'd1);
    checks++; if (soft_irq !== 2'b00) begin errors++; $display("FAIL soft_early got %b want 00", soft_irq); end
    @(posedge clk_timer); #1;
    checks++; if (soft_irq !== 2'b10) begin errors++; $display("FAIL soft_set got %b want 10", soft_irq); end
    wr(16'h4010, 32'h1234);
    wr(16'h0008, 32'd1);
    rd(16'h4010, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_cmp got %h want 0", d); end
    rd(16'h0008, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_msip got %h want 0", d); end
    rd(16'h0004, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL msip1_read got %h want 1", d); end
    checks++; if (soft_irq !== 2'b10) begin errors++; $display("FAIL soft_stable got %b want 10", soft_irq); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    wr(16'hBFF4, 32'd7);
    @(posedge clk_timer); #1;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 16'hBFF4;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_timer); #1;
      exp_ack = (k % 2 == 0);
      checks++; if (bus_ack !== exp_ack) begin errors++; $display("FAIL b2b_ack k=%0d got %b want %b", k, bus_ack, exp_ack); end
      checks++; if (bus_rdata !== (exp_ack ? 32'd7 : 32'd0)) begin errors++; $display("FAIL b2b_rdata k=%0d got %h want %h", k, bus_rdata, exp_ack ? 32'd7 : 32'd0); end
    end
    bus_req = 1'b0;
    @(posedge clk_timer); #1;
    checks++; if (bus_ack !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus_ack); end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_compare();
    test_coherent();
    test_wrap();
    test_soft();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtimer_multi.md
Name: mtimer_multi

Overview:
- Parametrised machine-timer block with NUM_CH independent compare channels plus software-interrupt bits.
- Owns one shared 64-bit mtime counter, driven by a programmable prescaler and an enable bit.
- Register-mapped on a simple req/ack bus clocked by clk_timer.
- Feeds registered timer_irq/soft_irq lines to each consumer's CSR mip bits.
- Adds several features the single-channel timer lacks: multi-channel compare, prescaling, a run/stop control, coherent 64-bit reads, and a handshaked bus.

Parameters:
NUM_CH, 2, number of compare/soft-interrupt channels (1..16).
TIME_WIDTH, 64, mtime/mtimecmp width (33..64); reads zero-extend above TIME_WIDTH.
PRESCALE_WIDTH, 16, prescaler divider width (1..32).

Ports:
clk_timer  input  1  timer clock; all logic is synchronous to it.
rst  input  1  asynchronous, active-low reset.
bus_req  input  1  access request; held high until bus_ack.
bus_we  input  1  1 = write, 0 = read; qualified by bus_req.
bus_addr  input  16  byte address, word aligned; bits[1:0] ignored.
bus_wdata  input  32  write data.
bus_ack  output  1  one-cycle completion pulse.
bus_rdata  output  32  read data, valid while bus_ack=1.
timer_irq  output  NUM_CH  per-channel (mtime >= mtimecmp[i]), registered.
soft_irq  output  NUM_CH  per-channel msip[i], registered.
tick  output  1  one-cycle pulse when mtime increments.

Behaviour:
- Reset (rst=0, async):
  - mtime=0, every mtimecmp = all ones, msip=0.
  - en=1, prescale=0, prescale counter=0, hi_shadow=0.
  - bus_ack=0, bus_rdata=0, timer_irq=0, soft_irq=0, tick=0.
  - Reset mid-transaction aborts it; no ack is issued.
- Register map (32-bit words):
  - 0x0000+4i: msip[i], bit0 only.
  - 0x4000+8i: mtimecmp[i] low word.
  - 0x4004+8i: mtimecmp[i] high word.
  - 0xBFF0: ctrl, bit0 = en.
  - 0xBFF4: prescale[PRESCALE_WIDTH-1:0].
  - 0xBFF8: mtime low word.
  - 0xBFFC: mtime high word.
  - Channel index i >= NUM_CH, or any other address: reads 0, writes ignored, still acked.
- Bus FSM:
  - IDLE: bus_req=1 → perform the access this cycle, go to ACK.
  - ACK: bus_ack=1 and bus_rdata driven; always return to IDLE. A req still high in ACK is not re-sampled.
  - Back-to-back accesses: one every 2 cycles. Ack latency is 1 cycle after acceptance.
  - bus_rdata returns to 0 when bus_ack=0.
- Coherent read: reading mtime low (0xBFF8) copies mtime high into hi_shadow in the same cycle. Reading 0xBFFC returns hi_shadow, not live mtime.
- Prescaler (when en=1):
  - Counter pc increments every cycle.
  - When pc==prescale: tick=1 for one cycle, mtime+=1, pc=0.
  - Result: mtime advances every prescale+1 cycles.
- en=0 freezes both pc and mtime; tick=0.
- Writing prescale clears pc to 0 the same cycle.
- mtime wraps from all ones to 0 with no flag.
- Bus write to mtime low/high in the same cycle as a tick: the write wins, the increment is dropped, and pc still resets.
- Compare:
  - timer_irq[i] <= (mtime >= mtimecmp[i]), unsigned, full TIME_WIDTH, registered.
  - The output reflects mtime and mtimecmp values of the previous cycle.
  - A write to mtimecmp changes timer_irq 1 cycle after the write cycle.
  - Level sensitive: deasserts only by raising mtimecmp or by mtime wrapping.
- soft_irq[i] <= msip[i], registered; visible 1 cycle after the write cycle.
- 32-bit halves written separately. Software writes high=all ones, then low, then high to avoid spurious matches; the block enforces no atomicity.

Test Plan:
- Reset release, read 0xBFF8 and 0x4004 → 0 and 0xFFFFFFFF. timer_irq=0, soft_irq=0, bus_ack one cycle after req.
- prescale=3, en=1 → tick every 4 cycles; mtime reads 5 after 20 cycles from the write.
- Channel1 mtimecmp={0,10}, prescale=0 → timer_irq[1] rises the cycle after mtime==10; timer_irq[0] stays 0. Writing high=1 clears timer_irq[1] next cycle.
- Write mtime={0x0,0xFFFFFFFF}, read low (0xFFFFFFFF) then high after the carry → high returns 0 (shadow). A later low read then high read returns 1.
- Write mtime all ones with a small compare value on channel 0 → mtime wraps to 0; timer_irq[0] falls one cycle later.
- Write msip[1]=1 and addr 0x4000+8*NUM_CH=0x1234 → soft_irq=2'b10 next cycle; the unmapped read returns 0; both accesses are acked.
